// File: rtl/afe_ro_sram_ctrl_pkg.sv
// afe_ro_sram_ctrl_pkg: shared types for the AFE readout SRAM controller
// Exports ctrl_state_e (IDLE/RUN/DRAIN), arb_side_e (ARB_WRITE/ARB_READ) and the arbiter reset side RR_RESET.
package afe_ro_sram_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} ctrl_state_e;
    typedef enum logic {ARB_WRITE, ARB_READ} arb_side_e;
    localparam arb_side_e RR_RESET = ARB_READ;
endpackage

// File: rtl/afe_ro_rr_arb2.sv
// afe_ro_rr_arb2: two-way round-robin arbiter, bit ARB_WRITE and bit ARB_READ
// Ports: clk_i, rst_ni (async active-low), request[1:0] in, grant[1:0] out (one-hot or zero).
module afe_ro_rr_arb2
    import afe_ro_sram_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] request,
    output logic [1:0] grant
);
    arb_side_e rr_last;
    // on a contested cycle the side that did not win last time gets the port
    assign grant[ARB_WRITE] = request[ARB_WRITE] && (!request[ARB_READ] || rr_last == ARB_READ);
    assign grant[ARB_READ]  = request[ARB_READ] && (!request[ARB_WRITE] || rr_last == ARB_WRITE);
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni)
            rr_last <= RR_RESET;
        else if (&request)
            rr_last <= grant[ARB_WRITE] ? ARB_WRITE : ARB_READ;
endmodule

// File: rtl/afe_ro_sram_ctrl.sv
// afe_ro_sram_ctrl: circular-buffer controller between the AFE sample stream and a single-port SRAM
// Ports: clk_i/rst_ni; cfg_en_i, cfg_clr_i, cfg_thr_i config; afe_valid_i/afe_data_i sample in;
// rd_req_i/rd_gnt_o/rd_rvalid_o/rd_rdata_o pop side; sram_cen_o/wen_o/addr_o/wdata_o/rdata_i SRAM pins;
// fill_o, empty_o, full_o, ovf_o, thr_irq_o status.
module afe_ro_sram_ctrl
    import afe_ro_sram_ctrl_pkg::*;
#(
    parameter int AFE_DATA_WIDTH = 32,
    parameter int ADDR_WIDTH     = 10
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      cfg_en_i,
    input  logic                      cfg_clr_i,
    input  logic [ADDR_WIDTH:0]       cfg_thr_i,
    input  logic                      afe_valid_i,
    input  logic [AFE_DATA_WIDTH-1:0] afe_data_i,
    input  logic                      rd_req_i,
    output logic                      rd_gnt_o,
    output logic                      rd_rvalid_o,
    output logic [AFE_DATA_WIDTH-1:0] rd_rdata_o,
    output logic                      sram_cen_o,
    output logic                      sram_wen_o,
    output logic [ADDR_WIDTH-1:0]     sram_addr_o,
    output logic [AFE_DATA_WIDTH-1:0] sram_wdata_o,
    input  logic [AFE_DATA_WIDTH-1:0] sram_rdata_i,
    output logic [ADDR_WIDTH:0]       fill_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic                      ovf_o,
    output logic                      thr_irq_o
);
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    ctrl_state_e               state;
    logic                      pend_vld;
    logic [AFE_DATA_WIDTH-1:0] pend_data;
    logic [ADDR_WIDTH-1:0]     wptr, rptr;
    logic [ADDR_WIDTH:0]       fill;
    logic                      ovf_q, rvalid_q, irq_q;
    logic [1:0]                grant;
    logic                      wr_gnt, rd_gnt, capture, load, irq_next;

    assign fill_o      = fill;
    assign empty_o     = fill == '0;
    assign full_o      = fill == DEPTH;
    assign ovf_o       = ovf_q;
    assign thr_irq_o   = irq_q;
    assign rd_rvalid_o = rvalid_q;
    assign rd_rdata_o  = sram_rdata_i;

    // a clear cycle masks both requests, so nothing is granted and rr_last holds
    afe_ro_rr_arb2 u_arb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .request ({rd_req_i && !empty_o, pend_vld && !full_o} & {2{!cfg_clr_i}}),
        .grant   (grant)
    );

    assign wr_gnt   = grant[ARB_WRITE];
    assign rd_gnt   = grant[ARB_READ];
    assign rd_gnt_o = rd_gnt;

    assign sram_cen_o   = !(wr_gnt || rd_gnt);
    assign sram_wen_o   = !wr_gnt;
    assign sram_addr_o  = wr_gnt ? wptr : rd_gnt ? rptr : '0;
    assign sram_wdata_o = wr_gnt ? pend_data : '0;

    // the pending slot can take a new sample in the same cycle it drains into the SRAM
    assign capture  = state == RUN && afe_valid_i && !cfg_clr_i;
    assign load     = capture && (!pend_vld || wr_gnt);
    assign irq_next = wr_gnt && cfg_thr_i != '0 && fill < cfg_thr_i && fill + 1'b1 >= cfg_thr_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            pend_vld  <= 1'b0;
            pend_data <= '0;
            wptr      <= '0;
            rptr      <= '0;
            fill      <= '0;
            ovf_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state    <= (state == IDLE && cfg_en_i)   ? RUN   :
                        (state == RUN && !cfg_en_i)   ? DRAIN :
                        (state == DRAIN && !pend_vld) ? IDLE  : state;
            rvalid_q <= rd_gnt;
            irq_q    <= irq_next;
            if (cfg_clr_i) begin
                wptr     <= '0;
                rptr     <= '0;
                fill     <= '0;
                pend_vld <= 1'b0;
                ovf_q    <= 1'b0;
            end else begin
                if (wr_gnt) wptr <= wptr + 1'b1;
                if (rd_gnt) rptr <= rptr + 1'b1;
                if (wr_gnt) fill <= fill + 1'b1;
                else if (rd_gnt) fill <= fill - 1'b1;
                if (load) begin
                    pend_vld  <= 1'b1;
                    pend_data <= afe_data_i;
                end else if (wr_gnt) begin
                    pend_vld <= 1'b0;
                end
                if (capture && !load) ovf_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_afe_ro_sram_ctrl.sv
// tb_afe_ro_sram_ctrl: directed and random stimulus against a queue-based model of the readout buffer
module tb_afe_ro_sram_ctrl;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int D  = 16;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          cfg_en = 0, cfg_clr = 0, afe_valid = 0, rd_req = 0;
    logic [AW:0]   cfg_thr = '0;
    logic [DW-1:0] afe_data = '0, sram_rdata = '0;
    logic          rd_gnt, rd_rvalid, sram_cen, sram_wen, empty, full, ovf, thr_irq;
    logic [DW-1:0] rd_rdata, sram_wdata;
    logic [AW-1:0] sram_addr;
    logic [AW:0]   fill;
    logic [DW-1:0] mem [D];

    always #5 clk = ~clk;

    afe_ro_sram_ctrl #(.AFE_DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .cfg_en_i(cfg_en), .cfg_clr_i(cfg_clr), .cfg_thr_i(cfg_thr),
        .afe_valid_i(afe_valid), .afe_data_i(afe_data), .rd_req_i(rd_req), .rd_gnt_o(rd_gnt),
        .rd_rvalid_o(rd_rvalid), .rd_rdata_o(rd_rdata), .sram_cen_o(sram_cen), .sram_wen_o(sram_wen),
        .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata),
        .fill_o(fill), .empty_o(empty), .full_o(full), .ovf_o(ovf), .thr_irq_o(thr_irq)
    );

    // behavioural single-port SRAM with one-cycle read latency
    always @(posedge clk)
        if (!sram_cen) begin
            if (!sram_wen) mem[sram_addr] <= sram_wdata;
            else sram_rdata <= mem[sram_addr];
        end

    int            checks = 0, passed = 0;
    logic [DW-1:0] q [$];
    bit            pv, m_ovf, last_w;
    logic [DW-1:0] pd, exp_rd;
    int            st, wp, rp, thr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        q.delete();
        pv = 0; m_ovf = 0; last_w = 0; st = 0; wp = 0; rp = 0;
    endtask

    // one clock: drive inputs, predict and check the access, then check registered results
    task automatic cyc(input bit en, input bit clr, input bit v, input logic [DW-1:0] d, input bit req);
        bit we, re, wg, rg, irq;
        int fb, ns;
        cfg_en = en; cfg_clr = clr; afe_valid = v; afe_data = d; rd_req = req;
        cfg_thr = (AW+1)'(thr);
        fb = q.size();
        we = pv && fb < D && !clr;
        re = req && fb > 0 && !clr;
        if (we && re) begin
            wg = !last_w; rg = last_w; last_w = wg;
        end else begin
            wg = we; rg = re;
        end
        #1;
        chk("rd_gnt", 64'(rd_gnt), 64'(rg));
        chk("sram_cen", 64'(sram_cen), 64'(!(wg || rg)));
        chk("sram_wen", 64'(sram_wen), 64'(!wg));
        chk("sram_addr", 64'(sram_addr), 64'(wg ? wp % D : rg ? rp % D : 0));
        if (wg) chk("sram_wdata", 64'(sram_wdata), 64'(pd));
        @(posedge clk); #1;
        if (rg) begin exp_rd = q.pop_front(); rp++; end
        if (wg) begin q.push_back(pd); wp++; end
        irq = wg && thr != 0 && fb < thr && fb + 1 >= thr;
        ns = (st == 0 && en) ? 1 : (st == 1 && !en) ? 2 : (st == 2 && !pv) ? 0 : st;
        if (clr) begin q.delete(); wp = 0; rp = 0; pv = 0; m_ovf = 0; end
        else if (st == 1 && v && (!pv || wg)) begin pv = 1; pd = d; end
        else if (st == 1 && v) m_ovf = 1;
        else if (wg) pv = 0;
        st = ns;
        chk("fill", 64'(fill), 64'(q.size()));
        chk("empty", 64'(empty), 64'(q.size() == 0));
        chk("full", 64'(full), 64'(q.size() == D));
        chk("ovf", 64'(ovf), 64'(m_ovf));
        chk("thr_irq", 64'(thr_irq), 64'(irq));
        chk("rd_rvalid", 64'(rd_rvalid), 64'(rg));
        if (rg) chk("rd_rdata", 64'(rd_rdata), 64'(exp_rd));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_fill"}, 64'(fill), 64'd0);
        chk({tag, "_empty"}, 64'(empty), 64'd1);
        chk({tag, "_full"}, 64'(full), 64'd0);
        chk({tag, "_ovf"}, 64'(ovf), 64'd0);
        chk({tag, "_irq"}, 64'(thr_irq), 64'd0);
        chk({tag, "_rvalid"}, 64'(rd_rvalid), 64'd0);
        chk({tag, "_cen"}, 64'(sram_cen), 64'd1);
        chk({tag, "_wen"}, 64'(sram_wen), 64'd1);
        chk({tag, "_addr"}, 64'(sram_addr), 64'd0);
        chk({tag, "_wdata"}, 64'(sram_wdata), 64'd0);
        chk({tag, "_gnt"}, 64'(rd_gnt), 64'd0);
    endtask

    initial begin
        int irq_n;
        thr = 0;
        model_reset();
        #3;
        check_reset_state("reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // five samples in, five pops out in order
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 1, DW'(32'h11 + i), 0);
        cyc(1, 0, 0, 0, 0);
        chk("fill_after_5", 64'(fill), 64'd5);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0, 0, 1);
            chk("pop_data", 64'(rd_rdata), 64'(32'h11 + i));
        end
        cyc(1, 0, 0, 0, 1);
        chk("empty_after_pops", 64'(empty), 64'd1);

        // contested port: writes and reads alternate, blocked sample overflows
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, $urandom, 0);
        cyc(1, 0, 0, 0, 0);
        chk("fill_3", 64'(fill), 64'd3);
        for (int i = 0; i < 8; i++) cyc(1, 0, 1, $urandom, 1);
        chk("ovf_contested", 64'(ovf), 64'd1);

        // fill to full, hold the 17th, drop the 18th, pop to release
        cyc(1, 1, 0, 0, 0);
        for (int i = 0; i < 18; i++) cyc(1, 0, 1, $urandom, 0);
        chk("full_16", 64'(full), 64'd1);
        chk("ovf_full", 64'(ovf), 64'd1);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0);
        chk("refill_16", 64'(fill), 64'd16);

        // threshold interrupt fires once when crossing 4
        cyc(1, 1, 0, 0, 0);
        thr = 4;
        irq_n = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 1, $urandom, 0);
            irq_n += int'(thr_irq);
            cyc(1, 0, 0, 0, 0);
            irq_n += int'(thr_irq);
        end
        chk("irq_pulses", 64'(irq_n), 64'd1);
        thr = 0;

        // pointers wrap across address 15 -> 0
        cyc(1, 1, 0, 0, 0);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 5; i++) cyc(1, 0, 1, $urandom, 0);
            cyc(1, 0, 0, 0, 0);
            for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 1);
        end
        chk("wrap_empty", 64'(empty), 64'd1);

        // clear with a read in flight
        cyc(1, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc(1, 0, 1, $urandom, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 1, 1, $urandom, 1);
        chk("clr_fill", 64'(fill), 64'd0);
        chk("clr_empty", 64'(empty), 64'd1);
        chk("clr_ovf", 64'(ovf), 64'd0);

        // random traffic, including DRAIN/IDLE transitions and occasional clears
        for (int i = 0; i < 500; i++) begin
            if (i % 50 == 0) thr = $urandom_range(0, D);
            cyc($urandom_range(0, 7) != 0, $urandom_range(0, 40) == 0,
                $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 2) == 0);
        end

        // asynchronous reset mid-operation
        thr = 0;
        for (int i = 0; i < 4; i++) cyc(1, 0, 1, $urandom, 0);
        cfg_en = 0; afe_valid = 0; rd_req = 0; cfg_clr = 0; cfg_thr = '0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_state("async_reset");
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, $urandom, 1);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/afe_ro_sram_ctrl.md
Name: afe_ro_sram_ctrl

Overview:
- Single-port SRAM circular-buffer controller sitting between the AFE sample stream and the readout pop interface.
- Captures AFE samples into a one-entry pending register so the AFE is never stalled.
- Arbitrates the single SRAM port between pending writes and readout pops, round-robin.
- Maintains read/write pointers, fill level, sticky overflow and threshold interrupt; drives the cen/wen/addr/wdata pins of the SRAM buffer block.

Parameters:
- AFE_DATA_WIDTH, 32, sample width (<=32).
- ADDR_WIDTH, 10, SRAM address width; depth D = 2**ADDR_WIDTH.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- cfg_en_i  in  1  accept AFE samples when high
- cfg_clr_i  in  1  one-cycle pulse: clear pointers, fill, pending, ovf
- cfg_thr_i  in  ADDR_WIDTH+1  fill threshold for thr_irq_o; 0 disables
- afe_valid_i  in  1  sample strobe, no backpressure
- afe_data_i  in  AFE_DATA_WIDTH  sample
- rd_req_i  in  1  pop request, held until granted
- rd_gnt_o  out  1  pop accepted this cycle
- rd_rvalid_o  out  1  pop data valid
- rd_rdata_o  out  AFE_DATA_WIDTH  pop data
- sram_cen_o  out  1  active-low chip enable
- sram_wen_o  out  1  active-low write enable
- sram_addr_o  out  ADDR_WIDTH  address
- sram_wdata_o  out  AFE_DATA_WIDTH  write data
- sram_rdata_i  in  AFE_DATA_WIDTH  read data, valid one cycle after read access
- fill_o  out  ADDR_WIDTH+1  current occupancy 0..D
- empty_o  out  1  fill==0
- full_o  out  1  fill==D
- ovf_o  out  1  sticky sample-drop flag
- thr_irq_o  out  1  one-cycle pulse

Behaviour:
- Reset values: pointers=0, fill=0, pending empty, ovf=0, rd_rvalid_o=0, thr_irq_o=0, rr_last=READ, state=IDLE.
  - Combinational outputs at reset: sram_cen_o=1, sram_wen_o=1, sram_addr_o=0, sram_wdata_o=0, rd_gnt_o=0.
- FSM: IDLE, RUN, DRAIN.
  - IDLE->RUN when cfg_en_i=1.
  - RUN->DRAIN when cfg_en_i=0.
  - DRAIN->IDLE when pending is empty.
  - Samples are captured only in RUN. Reads are serviced in every state.
- Capture: afe_valid_i in RUN loads pending if it is empty, or if it is being committed this same cycle.
  - Otherwise the sample is dropped and ovf_o is set next cycle.
- Write eligibility: pending valid and not full. A pending sample waits while full; it is never discarded except by cfg_clr_i.
- Read eligibility: rd_req_i and not empty.
- Arbitration (one access per cycle):
  - Only one side eligible -> it wins.
  - Both eligible -> grant the side opposite rr_last.
  - rr_last updates only on contested cycles.
- Write grant: sram_cen_o=0, sram_wen_o=0, addr=wptr, wdata=pending. Then wptr+1, fill+1, pending cleared.
- Read grant: rd_gnt_o=1, sram_cen_o=0, sram_wen_o=1, addr=rptr. Then rptr+1, fill-1.
  - rd_rvalid_o=1 exactly one cycle later, with rd_rdata_o = sram_rdata_i (combinational pass-through).
- Pointers are ADDR_WIDTH bits and wrap D-1 -> 0 naturally. fill never increments and decrements in the same cycle.
- thr_irq_o pulses the cycle after a write commit where fill goes from < cfg_thr_i to >= cfg_thr_i, with cfg_thr_i != 0.
- cfg_clr_i has highest priority:
  - No grant in that cycle.
  - Next cycle: pointers=0, fill=0, pending empty, ovf=0.
  - FSM state unchanged. An rd_rvalid_o already in flight still completes.
- cfg_clr_i coincident with afe_valid_i: the sample is discarded without setting ovf.
- Reset mid-operation: all state returns to reset values asynchronously. SRAM contents are undefined and not relied upon.

Decomposition:
- Package afe_ro_sram_ctrl_pkg holds:
  - ctrl_state_e {IDLE, RUN, DRAIN}
  - arb_side_e {ARB_WRITE, ARB_READ}
  - constant RR_RESET = ARB_READ
- One sub-module, afe_ro_rr_arb2: 2-way round-robin arbiter with request[1:0], grant[1:0] and an internal rr_last register on clk_i/rst_ni.

Test Plan (ADDR_WIDTH=4, D=16):
- Write 5 samples 0x11..0x15 in RUN, then hold rd_req_i for 5 pops -> rd_rdata_o 0x11..0x15 in order; fill 5->0; empty_o=1 at end.
- afe_valid_i every cycle while rd_req_i is held high with fill=3 -> grants alternate W,R,W,R; sample on non-write cycle with pending occupied drops -> ovf_o=1.
- 16 writes then a 17th sample -> full_o=1, 17th held pending, 18th dropped, ovf_o=1; one pop -> pending committed, fill returns to 16.
- cfg_thr_i=4: write 4 samples -> single thr_irq_o pulse after 4th commit; 5th write -> no pulse.
- Fill and drain 20 samples in steps so pointers wrap -> data order intact across address 15->0.
- cfg_clr_i with fill=7 and a read in flight -> rd_rvalid_o still delivered; next cycle fill_o=0, ovf_o=0, empty_o=1; rd_req_i gets no grant.
